// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/issue controller: fetches 1-3 instruction bytes with the PC frozen,
// issues them to execute, then releases the PC for one cycle. Optional macro: FETCH_SSTEP_EN.
module fetch_sequencer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef FETCH_SSTEP_EN
    input  logic                  dbg_step,
`endif
    input  logic [ADDR_WIDTH-1:0] pc,
    output logic                  pc_halt,
    output logic                  pc_jump_en,
    output logic [ADDR_WIDTH-1:0] pc_jump_addr,
    output logic [1:0]            pc_instr_size,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_opcode,
    output logic [DATA_WIDTH-1:0] instr_op1,
    output logic [DATA_WIDTH-1:0] instr_op2,
    output logic [1:0]            instr_size,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_addr,
    output logic                  cpu_halted
);

    typedef enum logic [2:0] {
        FETCH0,
        FETCH1,
        FETCH2,
        ISSUE,
        ADVANCE,
        HALTED
`ifdef FETCH_SSTEP_EN
        , WAIT_STEP
`endif
    } state_t;

`ifdef FETCH_SSTEP_EN
    localparam state_t RESET_STATE = WAIT_STEP;
    localparam state_t AFTER_ADV   = WAIT_STEP;
`else
    localparam state_t RESET_STATE = FETCH0;
    localparam state_t AFTER_ADV   = FETCH0;
`endif

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   opcode_q, opcode_d;
    logic [DATA_WIDTH-1:0]   op1_q, op1_d;
    logic [DATA_WIDTH-1:0]   op2_q, op2_d;
    logic                    branch_q, branch_d;
    logic [ADDR_WIDTH-1:0]   target_q, target_d;

    // Instruction length lives in the two top opcode bits; 00 and 11 are single-byte.
    function automatic logic [1:0] size_of(input logic [DATA_WIDTH-1:0] op);
        case (op[DATA_WIDTH-1 -: 2])
            2'b01:   return 2'd2;
            2'b10:   return 2'd3;
            default: return 2'd1;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RESET_STATE;
            opcode_q <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            branch_q <= 1'b0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            branch_q <= branch_d;
            target_q <= target_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        branch_d = branch_q;
        target_d = target_q;
        case (state_q)
            FETCH0: if (mem_ready) begin
                opcode_d = mem_rdata;
                op1_d    = '0;
                op2_d    = '0;
                state_d  = (size_of(mem_rdata) >= 2'd2) ? FETCH1 : ISSUE;
            end
            FETCH1: if (mem_ready) begin
                op1_d   = mem_rdata;
                state_d = (size_of(opcode_q) == 2'd3) ? FETCH2 : ISSUE;
            end
            FETCH2: if (mem_ready) begin
                op2_d   = mem_rdata;
                state_d = ISSUE;
            end
            ISSUE: if (instr_ready) begin
                branch_d = branch_taken;
                target_d = branch_addr;
                state_d  = (opcode_q == '1) ? HALTED : ADVANCE;
            end
            ADVANCE: state_d = AFTER_ADV;
            HALTED:  state_d = HALTED;
`ifdef FETCH_SSTEP_EN
            WAIT_STEP: if (dbg_step) state_d = FETCH0;
`endif
            default: state_d = RESET_STATE;
        endcase
    end

    // mem_req is gated by rst_n so it falls the moment reset asserts.
    assign mem_req = rst_n && (state_q == FETCH0 || state_q == FETCH1 || state_q == FETCH2);

    always_comb begin
        mem_addr = pc;
        case (state_q)
            FETCH1:  mem_addr = pc + ADDR_WIDTH'(1);
            FETCH2:  mem_addr = pc + ADDR_WIDTH'(2);
            default: mem_addr = pc;
        endcase
    end

    assign pc_halt       = (state_q != ADVANCE);
    assign pc_jump_en    = (state_q == ADVANCE) && branch_q;
    assign pc_jump_addr  = target_q;
    assign pc_instr_size = size_of(opcode_q);
    assign instr_valid   = (state_q == ISSUE);
    assign instr_opcode  = opcode_q;
    assign instr_op1     = op1_q;
    assign instr_op2     = op2_q;
    assign instr_size    = size_of(opcode_q);
    assign cpu_halted    = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: program memory, PC unit and a transaction-level reference model.
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] pc;
    logic       pc_halt, pc_jump_en;
    logic [7:0] pc_jump_addr;
    logic [1:0] pc_instr_size;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ready;
    logic [7:0] mem_rdata;
    logic       instr_valid, instr_ready;
    logic [7:0] instr_opcode, instr_op1, instr_op2;
    logic [1:0] instr_size;
    logic       branch_taken;
    logic [7:0] branch_addr;
    logic       cpu_halted;

    logic [7:0] mem [256];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc),
        .pc_halt(pc_halt), .pc_jump_en(pc_jump_en), .pc_jump_addr(pc_jump_addr),
        .pc_instr_size(pc_instr_size), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr_opcode(instr_opcode), .instr_op1(instr_op1),
        .instr_op2(instr_op2), .instr_size(instr_size), .branch_taken(branch_taken),
        .branch_addr(branch_addr), .cpu_halted(cpu_halted)
    );

    // Memory returns garbage when not ready, so early captures are visible.
    assign mem_rdata = mem_ready ? mem[mem_addr] : 8'hEE;

    // PC unit
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= 8'h00;
        else if (!pc_halt) pc <= pc_jump_en ? pc_jump_addr : pc + {6'd0, pc_instr_size};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_size(input logic [7:0] op);
        if (op[7:6] == 2'b01) return 2;
        if (op[7:6] == 2'b10) return 3;
        return 1;
    endfunction

    // Reference model state: where the current instruction lives and how far its fetch has got.
    logic [7:0] ref_pc;
    int         rd_cnt, tot;
    bit         adv, halted, br;
    logic [7:0] br_addr;
    int         adv_size;
    int         cyc, acc_n, rd_n;

    logic [7:0] addr_log [64];
    logic [7:0] op_log   [64];
    logic [7:0] pc_log   [64];
    bit         req_log  [64];
    bit         halt_log [64];
    bit         jump_log [64];
    bit         valid_log[64];
    int         acc_cyc  [16];
    logic [7:0] acc_op   [16];
    logic [7:0] acc_op1  [16];
    logic [7:0] acc_op2  [16];
    logic [7:0] rd_addr  [16];

    always @(negedge clk) begin
        bit exp_req, exp_val;
        logic [7:0] a, e1, e2;
        if (!rst_n) begin
            ref_pc = 8'h00; rd_cnt = 0; tot = 0; adv = 0; halted = 0; br = 0;
            br_addr = 8'h00; adv_size = 1; cyc = 0; acc_n = 0; rd_n = 0;
        end else begin
            exp_req = !adv && !halted && (tot == 0 || rd_cnt < tot);
            exp_val = !adv && !halted && tot != 0 && rd_cnt == tot;
            check("pc_halt", pc_halt, !adv);
            check("pc_jump_en", pc_jump_en, adv && br);
            if (adv) begin
                check("pc_instr_size", pc_instr_size, adv_size);
                if (br) check("pc_jump_addr", pc_jump_addr, br_addr);
            end
            check("mem_req", mem_req, exp_req);
            if (exp_req) begin
                a = ref_pc + 8'(rd_cnt);
                check("mem_addr", mem_addr, a);
            end
            check("instr_valid", instr_valid, exp_val);
            if (exp_val) begin
                a  = ref_pc + 8'd1;
                e1 = (tot >= 2) ? mem[a] : 8'h00;
                a  = ref_pc + 8'd2;
                e2 = (tot == 3) ? mem[a] : 8'h00;
                check("instr_opcode", instr_opcode, mem[ref_pc]);
                check("instr_op1", instr_op1, e1);
                check("instr_op2", instr_op2, e2);
                check("instr_size", instr_size, tot);
            end
            check("cpu_halted", cpu_halted, halted);
            if (!adv) check("pc", pc, ref_pc);

            if (cyc < 64) begin
                addr_log[cyc] = mem_addr; op_log[cyc] = instr_opcode; pc_log[cyc] = pc;
                req_log[cyc] = mem_req; halt_log[cyc] = pc_halt; jump_log[cyc] = pc_jump_en;
                valid_log[cyc] = instr_valid;
            end

            if (adv) begin
                adv = 0; rd_cnt = 0; tot = 0;
            end else if (exp_req && mem_req && mem_ready) begin
                if (rd_cnt == 0) tot = exp_size(mem[ref_pc]);
                if (rd_n < 16) rd_addr[rd_n] = mem_addr;
                rd_n++;
                rd_cnt++;
            end else if (exp_val && instr_valid && instr_ready) begin
                if (acc_n < 16) begin
                    acc_cyc[acc_n] = cyc; acc_op[acc_n] = instr_opcode;
                    acc_op1[acc_n] = instr_op1; acc_op2[acc_n] = instr_op2;
                end
                $display("issue #%0d cyc=%0d pc=%02h op=%02h %02h %02h size=%0d br=%0b->%02h",
                         acc_n, cyc, ref_pc, instr_opcode, instr_op1, instr_op2, instr_size,
                         branch_taken, branch_addr);
                acc_n++;
                if (mem[ref_pc] == 8'hFF) halted = 1;
                else begin
                    adv = 1; br = branch_taken; br_addr = branch_addr; adv_size = tot;
                    ref_pc = branch_taken ? branch_addr : ref_pc + 8'(tot);
                end
            end
            cyc++;
        end
    end

    task automatic rst_assert();
        @(posedge clk); #1;
        rst_n = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic rst_release();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int req_sum;
        logic [7:0] v;
        rst_n = 1'b0; mem_ready = 1'b0; instr_ready = 1'b0;
        branch_taken = 1'b0; branch_addr = 8'h00;

        // 1-byte then 2-byte instruction, zero-wait, then HALT
        rst_assert();
        mem[0] = 8'h05; mem[1] = 8'h42; mem[2] = 8'h10; mem[3] = 8'hFF;
        mem_ready = 1'b1; instr_ready = 1'b1;
        rst_release();
        repeat (35) @(posedge clk); #1;
        check("p1_acc0_cyc", acc_cyc[0], 1);
        check("p1_acc1_cyc", acc_cyc[1], 5);
        check("p1_acc1_op", acc_op[1], 8'h42);
        check("p1_acc1_op1", acc_op1[1], 8'h10);
        check("p1_acc1_op2", acc_op2[1], 8'h00);
        check("p1_halted", cpu_halted, 1);
        check("p1_pc_at_halt", pc, 8'h03);
        req_sum = 0;
        for (int i = 9; i < 30; i++) req_sum += int'(req_log[i]);
        check("p1_no_req_halted", req_sum, 0);

        // 3-byte instruction straddling the address wrap
        rst_assert();
        mem[0] = 8'hBB; mem[1] = 8'hFF; mem[2] = 8'h00;
        mem[8'hFE] = 8'h80; mem[8'hFF] = 8'hAA;
        mem_ready = 1'b1; instr_ready = 1'b1; branch_taken = 1'b1; branch_addr = 8'hFE;
        rst_release();
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (acc_n >= 1) branch_taken = 1'b0;
        end
        check("p2_rd3", rd_addr[3], 8'hFE);
        check("p2_rd4", rd_addr[4], 8'hFF);
        check("p2_rd5", rd_addr[5], 8'h00);
        check("p2_acc1_op", acc_op[1], 8'h80);
        check("p2_acc1_op1", acc_op1[1], 8'hAA);
        check("p2_acc1_op2", acc_op2[1], 8'hBB);
        check("p2_pc_wrap", pc, 8'h01);

        // mem_ready low for three cycles in FETCH1
        rst_assert();
        mem[0] = 8'h42; mem[1] = 8'h10; mem[2] = 8'hFF;
        mem_ready = 1'b1; instr_ready = 1'b1;
        rst_release();
        @(posedge clk); #1 mem_ready = 1'b0;
        repeat (3) @(posedge clk); #1 mem_ready = 1'b1;
        repeat (20) @(posedge clk); #1;
        for (int i = 1; i <= 4; i++) begin
            check("p3_addr_hold", addr_log[i], 8'h01);
            check("p3_req_hold", req_log[i], 1);
            check("p3_halt_hold", halt_log[i], 1);
        end
        check("p3_acc_cyc", acc_cyc[0], 5);
        check("p3_op1", acc_op1[0], 8'h10);

        // instr_ready low five cycles, branch to 0x40 on accept
        rst_assert();
        mem[0] = 8'h42; mem[1] = 8'h33; mem[8'h40] = 8'hFF;
        mem_ready = 1'b1; instr_ready = 1'b0; branch_taken = 1'b1; branch_addr = 8'h40;
        rst_release();
        repeat (7) @(posedge clk); #1 instr_ready = 1'b1;
        repeat (20) @(posedge clk); #1;
        for (int i = 2; i <= 7; i++) begin
            check("p4_valid_hold", valid_log[i], 1);
            check("p4_op_stable", op_log[i], 8'h42);
        end
        check("p4_acc_cyc", acc_cyc[0], 7);
        check("p4_adv_halt", halt_log[8], 0);
        check("p4_adv_jump", jump_log[8], 1);
        check("p4_pc_jumped", pc_log[9], 8'h40);
        check("p4_halted", cpu_halted, 1);
        branch_taken = 1'b0;

        // randomised traffic, no HALT opcodes
        rst_assert();
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            mem[i] = (v == 8'hFF) ? 8'h7F : v;
        end
        rst_release();
        for (int i = 0; i < 3000; i++) begin
            mem_ready    = ($urandom_range(0, 3) != 0);
            instr_ready  = ($urandom_range(0, 3) != 0);
            branch_taken = ($urandom_range(0, 3) == 0);
            branch_addr  = 8'($urandom);
            @(posedge clk); #1;
        end
        check("p5_progress", acc_n > 200, 1);

        // asynchronous reset in the middle of FETCH2
        rst_assert();
        mem[0] = 8'h80; mem[1] = 8'h01; mem[2] = 8'h02; mem[3] = 8'hFF;
        mem_ready = 1'b1; instr_ready = 1'b1; branch_taken = 1'b0;
        rst_release();
        repeat (2) @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("p6_req_drop", mem_req, 0);
        check("p6_valid", instr_valid, 0);
        check("p6_pc_halt", pc_halt, 1);
        check("p6_jump_en", pc_jump_en, 0);
        check("p6_jump_addr", pc_jump_addr, 8'h00);
        check("p6_isize", pc_instr_size, 1);
        check("p6_opcode", instr_opcode, 8'h00);
        check("p6_halted", cpu_halted, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (15) @(posedge clk); #1;
        check("p6_restart_addr", addr_log[0], 8'h00);
        check("p6_restart_req", req_log[0], 1);
        check("p6_acc_cyc", acc_cyc[0], 3);
        check("p6_acc_op", acc_op[0], 8'h80);
        check("p6_acc_op2", acc_op2[0], 8'h02);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
